// File: rtl/game_timer_pkg.sv
// game_timer_pkg: shared types and helpers for the game round timer.
//   state_e    - controller states (idle, running, paused, expired/done)
//   SPD_*      - speed select encodings (1x, 2x, 4x, 8x)
//   calc_term  - prescaler terminal count for a given clock rate and speed
package game_timer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StDone
    } state_e;

    localparam logic [1:0] SPD_1X = 2'd0;
    localparam logic [1:0] SPD_2X = 2'd1;
    localparam logic [1:0] SPD_4X = 2'd2;
    localparam logic [1:0] SPD_8X = 2'd3;

    // Each speed step halves the period; clk_hz divisible by 8 keeps all four exact.
    function automatic int unsigned calc_term(input int unsigned clk_hz, input logic [1:0] spd);
        return (clk_hz >> spd) - 1;
    endfunction

endpackage

// File: rtl/game_timer_if.sv
// game_timer_if: command/status bundle between the game FSM and the round timer.
//   master - game FSM: drives start/stop/pause/resume, duration_s, speed; reads status
//   slave  - timer:    reads commands; drives seconds_left, tick, running, paused,
//                      expired, done
interface game_timer_if #(
    parameter int unsigned SEC_W = 8
);
    logic             start;
    logic             stop;
    logic             pause;
    logic             resume;
    logic [SEC_W-1:0] duration_s;
    logic [1:0]       speed;
    logic [SEC_W-1:0] seconds_left;
    logic             tick;
    logic             running;
    logic             paused;
    logic             expired;
    logic             done;

    modport master (
        output start, stop, pause, resume, duration_s, speed,
        input  seconds_left, tick, running, paused, expired, done
    );

    modport slave (
        input  start, stop, pause, resume, duration_s, speed,
        output seconds_left, tick, running, paused, expired, done
    );
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: programmable divider producing the per-period terminal strobe.
//   clk        - system clock
//   reset      - synchronous active-high reset
//   clear_i    - restart the period from zero
//   enable_i   - advance the count this clock
//   term_i     - terminal count (period - 1)
//   terminal_o - count has reached (or passed) term_i
module tick_prescaler #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          enable_i,
    input  logic [CW-1:0] term_i,
    output logic          terminal_o
);
    logic [CW-1:0] cnt_q;

    // >= rather than ==: after a speed-up on resume the held count may already be past
    // the new terminal, and that must count as terminal rather than wrap the full range.
    assign terminal_o = (cnt_q >= term_i);

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            cnt_q <= '0;
        end else if (enable_i) begin
            cnt_q <= terminal_o ? '0 : cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: countdown round timer with start/stop/pause/resume and speed select.
//   clk   - system clock (CLK_HZ)
//   reset - synchronous active-high reset
//   bus   - slave side of game_timer_if: commands in; seconds_left, tick, running,
//           paused, expired, done out (all registered)
module game_timer_ctrl
    import game_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned SEC_W  = 8
) (
    input logic         clk,
    input logic         reset,
    game_timer_if.slave bus
);
    localparam int unsigned CW = $clog2(CLK_HZ);

    state_e           state_q;
    logic [1:0]       spd_q;
    logic [SEC_W-1:0] sec_q;
    logic             tick_q;
    logic             running_q;
    logic             paused_q;
    logic             expired_q;
    logic             done_q;

    logic [CW-1:0]    term;
    logic             terminal;
    logic             pre_clear;
    logic             pre_enable;

    assign term       = CW'(calc_term(CLK_HZ, spd_q));
    assign pre_clear  = bus.stop || bus.start;
    // The clock on which pause is sampled still counts as run time.
    assign pre_enable = (state_q == StRun);

    tick_prescaler #(
        .CW (CW)
    ) u_prescaler (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (pre_clear),
        .enable_i   (pre_enable),
        .term_i     (term),
        .terminal_o (terminal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            spd_q     <= SPD_1X;
            sec_q     <= '0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
            expired_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            tick_q    <= 1'b0;
            expired_q <= 1'b0;
            if (bus.stop) begin
                state_q   <= StIdle;
                sec_q     <= '0;
                running_q <= 1'b0;
                paused_q  <= 1'b0;
                done_q    <= 1'b0;
            end else if (bus.start) begin
                spd_q    <= bus.speed;
                paused_q <= 1'b0;
                if (bus.duration_s != '0) begin
                    state_q   <= StRun;
                    sec_q     <= bus.duration_s;
                    running_q <= 1'b1;
                    done_q    <= 1'b0;
                end else begin
                    state_q   <= StDone;
                    sec_q     <= '0;
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                    expired_q <= 1'b1;
                end
            end else begin
                unique case (state_q)
                    StRun: begin
                        if (terminal && sec_q != '0) begin
                            tick_q <= 1'b1;
                            sec_q  <= sec_q - SEC_W'(1);
                        end
                        // Expiry outranks a coincident pause.
                        if (terminal && sec_q <= SEC_W'(1)) begin
                            state_q   <= StDone;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                            expired_q <= 1'b1;
                        end else if (bus.pause) begin
                            state_q   <= StPause;
                            running_q <= 1'b0;
                            paused_q  <= 1'b1;
                        end
                    end
                    StPause: begin
                        if (bus.resume) begin
                            spd_q     <= bus.speed;
                            state_q   <= StRun;
                            running_q <= 1'b1;
                            paused_q  <= 1'b0;
                        end
                    end
                    StIdle, StDone: begin
                        // Held until start or stop.
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.seconds_left = sec_q;
    assign bus.tick         = tick_q;
    assign bus.running      = running_q;
    assign bus.paused       = paused_q;
    assign bus.expired      = expired_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_game_timer_ctrl.sv
// tb_game_timer_ctrl: directed self-checking bench for game_timer_ctrl at CLK_HZ=16.
// Status flags are compared as {tick, running, paused, expired, done}.
module tb_game_timer_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   tick_cnt;

    game_timer_if #(.SEC_W(8)) bus ();

    game_timer_ctrl #(
        .CLK_HZ (16),
        .SEC_W  (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock; returns 1 time unit after the edge so outputs are sampled off-edge.
    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) clk1();
    endtask

    task automatic chk(input string tag, input logic [4:0] exp_flags, input logic [7:0] exp_sec);
        logic [4:0] obs_flags;
        obs_flags = {bus.tick, bus.running, bus.paused, bus.expired, bus.done};
        checks++;
        assert (obs_flags === exp_flags) else begin
            errors++;
            $error("FAIL %s flags: observed %b expected %b", tag, obs_flags, exp_flags);
        end
        checks++;
        assert (bus.seconds_left === exp_sec) else begin
            errors++;
            $error("FAIL %s seconds_left: observed %0d expected %0d", tag, bus.seconds_left,
                   exp_sec);
        end
    endtask

    task automatic do_start(input logic [7:0] dur, input logic [1:0] spd);
        bus.duration_s = dur;
        bus.speed      = spd;
        bus.start      = 1'b1;
        clk1();
        bus.start      = 1'b0;
    endtask

    task automatic pulse_pause();
        bus.pause = 1'b1;
        clk1();
        bus.pause = 1'b0;
    endtask

    task automatic pulse_resume(input logic [1:0] spd);
        bus.speed  = spd;
        bus.resume = 1'b1;
        clk1();
        bus.resume = 1'b0;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.pause      = 1'b0;
        bus.resume     = 1'b0;
        bus.duration_s = '0;
        bus.speed      = 2'd0;
        clk1();
        reset = 1'b0;
        chk("reset", 5'b00000, 8'd0);

        // Basic run: 3 s at 1x, period 16.
        do_start(8'd3, 2'd0);
        chk("basic_start", 5'b01000, 8'd3);
        cycles(15);
        chk("basic_pre_tick1", 5'b01000, 8'd3);
        clk1();
        chk("basic_tick1", 5'b11000, 8'd2);
        cycles(16);
        chk("basic_tick2", 5'b11000, 8'd1);
        cycles(15);
        chk("basic_pre_tick3", 5'b01000, 8'd1);
        clk1();
        chk("basic_expire", 5'b10011, 8'd0);
        clk1();
        chk("basic_done_hold", 5'b00001, 8'd0);
        cycles(20);
        chk("basic_done_still", 5'b00001, 8'd0);

        // Pause mid-period: 5 s at 4x, period 4.
        do_start(8'd5, 2'd2);
        cycles(3);
        chk("pm_pre_tick", 5'b01000, 8'd5);
        clk1();
        chk("pm_tick", 5'b11000, 8'd4);
        clk1();
        pulse_pause();
        chk("pm_paused", 5'b00100, 8'd4);
        tick_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            clk1();
            if (bus.tick) tick_cnt++;
        end
        checks++;
        assert (tick_cnt == 0) else begin
            errors++;
            $error("FAIL pm_no_tick: observed %0d ticks expected 0", tick_cnt);
        end
        chk("pm_still_paused", 5'b00100, 8'd4);
        pulse_resume(2'd2);
        chk("pm_resumed", 5'b01000, 8'd4);
        clk1();
        chk("pm_resume_1", 5'b01000, 8'd4);
        clk1();
        chk("pm_resume_tick", 5'b11000, 8'd3);

        // Pause coinciding with terminal.
        cycles(4);
        chk("pt_tick_to2", 5'b11000, 8'd2);
        cycles(3);
        pulse_pause();
        chk("pt_pause_on_term", 5'b10100, 8'd1);
        clk1();
        chk("pt_paused_hold", 5'b00100, 8'd1);
        pulse_resume(2'd2);
        cycles(3);
        chk("pt_pre_term", 5'b01000, 8'd1);
        pulse_pause();
        chk("pt_done_wins", 5'b10011, 8'd0);

        // Zero duration, then stop.
        do_start(8'd0, 2'd0);
        chk("zero_done", 5'b00011, 8'd0);
        clk1();
        chk("zero_hold", 5'b00001, 8'd0);
        bus.stop = 1'b1;
        clk1();
        bus.stop = 1'b0;
        chk("zero_stop", 5'b00000, 8'd0);

        // Stop beats start; a later start restarts mid-run.
        do_start(8'd3, 2'd0);
        cycles(16);
        chk("prio_at2", 5'b11000, 8'd2);
        bus.duration_s = 8'd7;
        bus.start      = 1'b1;
        bus.stop       = 1'b1;
        clk1();
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        chk("prio_stop_wins", 5'b00000, 8'd0);
        do_start(8'd3, 2'd0);
        cycles(10);
        do_start(8'd7, 2'd0);
        chk("restart_load", 5'b01000, 8'd7);
        bus.speed = 2'd3;   // not sampled outside start/resume
        cycles(15);
        chk("restart_pre_tick", 5'b01000, 8'd7);
        clk1();
        chk("restart_tick", 5'b11000, 8'd6);

        // Resume at a faster speed with held count beyond the new terminal.
        do_start(8'd5, 2'd0);
        cycles(9);
        pulse_pause();
        chk("fast_paused", 5'b00100, 8'd5);
        pulse_resume(2'd3);
        chk("fast_resumed", 5'b01000, 8'd5);
        clk1();
        chk("fast_immediate_tick", 5'b11000, 8'd4);
        clk1();
        chk("fast_gap", 5'b01000, 8'd4);
        clk1();
        chk("fast_tick2", 5'b11000, 8'd3);

        // Synchronous reset during pause; resume afterwards is ignored.
        pulse_pause();
        chk("rst_paused", 5'b00100, 8'd3);
        reset = 1'b1;
        clk1();
        reset = 1'b0;
        chk("rst_cleared", 5'b00000, 8'd0);
        pulse_resume(2'd0);
        chk("rst_resume_ignored", 5'b00000, 8'd0);
        cycles(20);
        chk("rst_stays_idle", 5'b00000, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/game_timer_ctrl.md
Name: game_timer_ctrl

Overview:
- Countdown-timer controller that sequences a shared 1 s timebase for game rounds.
- Owns an internal programmable prescaler and a seconds counter.
- Accepts start/stop/pause/resume commands from the game FSM.
- Emits per-second ticks, the remaining time for the HEX display, and an expiry pulse.
- Speed setting lets later levels run the clock 2x/4x/8x faster.

Parameters:
- CLK_HZ, 50000000, input clock frequency; must be divisible by 8.
- SEC_W, 8, width of the seconds counter and of duration_s.

Ports:
- clk  in  1  system clock (50 MHz on board).
- reset  in  1  synchronous, active-high; one clock; no other clock domains.
- start  in  1  one-cycle pulse: load duration_s and run.
- stop  in  1  one-cycle pulse: abort to idle.
- pause  in  1  one-cycle pulse: freeze countdown.
- resume  in  1  one-cycle pulse: continue countdown.
- duration_s  in  SEC_W  round length in seconds; sampled on start.
- speed  in  2  rate select: 0=1x, 1=2x, 2=4x, 3=8x; sampled on start and resume.
- seconds_left  out  SEC_W  remaining seconds.
- tick  out  1  one-cycle pulse on each decrement.
- running  out  1  high in RUN.
- paused  out  1  high in PAUSE.
- expired  out  1  one-cycle pulse on reaching zero.
- done  out  1  high in DONE.

Behaviour:
- All outputs are registered.
- Reset (synchronous, any state) gives: state IDLE, seconds_left=0, tick=0, running=0, paused=0, expired=0, done=0, prescaler count=0, latched speed=0.
- Prescaler operation:
  - Counts 0..TERM, where TERM=(CLK_HZ>>speed_latched)-1, and counts only in RUN.
  - Terminal is count==TERM; the count then wraps to 0.
  - Counter width is clog2(CLK_HZ).
- States: IDLE, RUN, PAUSE, DONE.
- Command priority: reset > stop > start > pause/resume > terminal tick.
- stop, in any state: go to IDLE, seconds_left=0, prescaler cleared.
- start, in any state:
  - Latch duration_s and speed, and clear the prescaler.
  - If duration_s!=0: go to RUN with seconds_left=duration_s.
  - If duration_s==0: go to DONE, seconds_left=0, expired pulses next cycle.
  - A start in RUN or PAUSE restarts the round.
- Latency: start sampled at edge N gives running=1 and seconds_left valid after edge N.
- First tick: period=TERM+1 clocks later. Subsequent ticks follow every period clocks.
- RUN on terminal:
  - tick=1 and seconds_left decrements in the same registered cycle.
  - If seconds_left was 1: it becomes 0, state goes to DONE, and expired=1 in that same cycle (tick also 1).
- RUN with pause:
  - Go to PAUSE and hold the prescaler count; time already accrued is not lost.
  - If pause coincides with terminal: the decrement is still applied, then PAUSE.
  - If that decrement reaches 0: DONE wins over PAUSE.
- PAUSE with resume:
  - Re-latch speed and go to RUN; the prescaler continues from the held count.
  - If the held count exceeds the new TERM, the next clock is treated as terminal.
- Ignored commands:
  - pause outside RUN and resume outside PAUSE are ignored.
  - speed changes outside start/resume are ignored.
- DONE holds seconds_left=0 and done=1 until start or stop.
- seconds_left never underflows; no decrement occurs in IDLE, PAUSE or DONE.
- Reset mid-round aborts immediately; nothing resumes.

Decomposition:
- Package game_timer_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - speed encodings SPD_1X..SPD_8X;
  - a function computing TERM from CLK_HZ and speed.
- One sub-module, tick_prescaler: clk, reset, clear, enable, term, and a terminal output.
  - Sync active-high reset; it replaces the free-running 1 s divider.
- The FSM and seconds counter stay in game_timer_ctrl.

Test Plan (CLK_HZ=16):
- Basic run: reset, then start with duration_s=3, speed=0.
  - running=1 next cycle.
  - ticks at +16, +32, +48 clocks.
  - seconds_left steps 3→2→1→0.
  - expired and tick both pulse on the third tick, then done=1, running=0.
- Pause mid-period: start with duration_s=5, speed=2 (period 4); pause 2 clocks after a tick; wait 20 clocks; resume.
  - No tick while paused; paused=1.
  - Next tick 2 clocks after resume; seconds_left continues from 4.
- Pause coinciding with terminal: pause in the same cycle as terminal with seconds_left=2.
  - seconds_left becomes 1, tick=1, state PAUSE.
  - Repeating with seconds_left=1 gives DONE with expired=1.
- Zero duration and stop: start with duration_s=0.
  - Next cycle done=1, expired one-cycle pulse, no tick.
  - Then stop gives IDLE, all outputs 0.
- Restart and priority: during RUN with seconds_left=2, assert start (duration_s=7) and stop together.
  - stop wins: IDLE.
  - A later start alone mid-run reloads 7 with a fresh 16-clock period.
- Sync reset: assert reset during PAUSE for 1 cycle.
  - All outputs 0 after that edge.
  - resume afterwards has no effect.
